uart_rx_errdet: RTL and testbench
=================================

// Module: uart_rx_errdet
// PURPOSE
//  Serial-to-parallel UART receiver with error detection for the rx_clk domain.
//  Oversamples the asynchronous rx line and recovers frames of 8N1 or 8E1/8O1.
//  Flags parity, framing and overrun errors per word.
//  Delivers each word through a one-entry valid/ready holding register, so it
//  is the receiving end of the link that the uart TX path drives.
// PARAMETERS
//  CLK_FREQ    50_000_000  rx_clk frequency, Hz
//  BAUD_RATE   115_200     line rate, bit/s
//  DATA_WIDTH  8           data bits per frame, sent LSB first
//  OVERSAMPLE  16          sample ticks per bit; even and >= 8
//  PARITY_EN   1           1: a parity bit follows the data bits
//  PARITY_ODD  0           0: even parity, 1: odd parity (ignored if PARITY_EN=0)
// PORTS
//  rx_clk       in   1           receiver clock
//  reset_n      in   1           asynchronous active-low reset
//  rx           in   1           serial line, idles high, asynchronous to rx_clk
//  RxData       out  DATA_WIDTH  received word, valid while rx_valid=1
//  rx_valid     out  1           holding register full
//  rx_ready     in   1           consumer accepts the word when rx_valid & rx_ready
//  parity_err   out  1           parity mismatch for RxData; qualified by rx_valid
//  frame_err    out  1           stop bit sampled low for RxData; qualified by rx_valid
//  overrun_err  out  1           1-cycle pulse: a completed frame was dropped
// BEHAVIOUR
//  - Reset: all outputs are 0, FSM=IDLE, synchroniser flops are 1, tick counter is 0.
//    Reset applied mid-frame aborts the frame and discards any held word.
//  - Synchronisation: rx passes through 2 flops (rxs) before any use.
//  - Tick generation:
//    TICK_DIV = (CLK_FREQ + BAUD_RATE*OVERSAMPLE/2) / (BAUD_RATE*OVERSAMPLE).
//    Defaults give TICK_DIV=27, a bit time of 8640 ns (-0.47%).
//    The tick counter restarts at 0 on start-edge detection so sampling is aligned to the edge.
//  - Bit sampling: samples are taken on ticks OVERSAMPLE/2-1, /2 and /2+1 of each bit.
//    The bit value is the majority of the 3 samples, resolved on tick /2+1.
//    After tick OVERSAMPLE-1 the bit counter advances.
//  - FSM states:
//    IDLE: rxs=0 -> START.
//    START: majority=1 -> IDLE (glitch rejected, nothing reported); majority=0 -> DATA, bit_cnt=0.
//    DATA: shift the voted bit in at the MSB, shift register right.
//      At bit_cnt=DATA_WIDTH-1, end of bit -> PARITY if PARITY_EN, else STOP.
//    PARITY: par_bad = ^{data,bit} ^ PARITY_ODD; at end of bit -> STOP.
//    STOP: on the resolve tick, commit (see below), then -> IDLE if voted 1, else -> WAIT_HIGH.
//      Does not wait for the end of the stop bit.
//    WAIT_HIGH: stay until rxs=1, then -> IDLE. Break or stuck-low never retriggers START.
//  - Commit: RxData, parity_err and frame_err are loaded together and rx_valid is set 1.
//    Commit latency is 1 rx_clk after the stop-bit resolve tick.
//  - Handshake:
//    rx_valid & rx_ready clears rx_valid next cycle; RxData holds its value.
//    Commit while rx_valid=1 & rx_ready=0: the new frame is dropped, the held word
//    is unchanged and overrun_err pulses for 1 cycle.
//    Commit in the same cycle as an accept: the new word loads, rx_valid stays 1, no overrun.
//  - Framing errors do not suppress delivery: the word is delivered with frame_err=1.
// STRUCTURE
//  - uart_pkg:
//    typedef enum logic [2:0] rx_state_e {IDLE,START,DATA,PARITY,STOP,WAIT_HIGH}.
//    function calc_tick_div(clk,baud,os).
//  - Sub-module uart_baud_tick (inputs: rx_clk, reset_n, clear; output: tick pulse).
//    Parameterised by TICK_DIV; reused by the TX side.
//  - Elaboration checks:
//    $error if TICK_DIV<1.
//    $error if OVERSAMPLE is odd or less than 8.
// TESTING (defaults; bit time 8640 ns; 'E'=0x45, even parity bit 1)
//  1. Frame 0x45, parity=1, stop=1, rx_ready=1
//     -> rx_valid 1 cycle, RxData=0x45, parity_err=0, frame_err=0.
//  2. Frame 0x45, parity=0 -> RxData=0x45, parity_err=1, frame_err=0.
//  3. Frame 0x4E, stop=0, line held low 3 bit times
//     -> one word with frame_err=1; FSM in WAIT_HIGH; no second rx_valid.
//  4. 200 ns low glitch on idle line, then 300 ns low glitch
//     -> no rx_valid; FSM returns to IDLE each time.
//  5. "E","N" back-to-back with rx_ready=0
//     -> RxData stays 0x45, overrun_err pulses once.
//     Then raise rx_ready -> rx_valid falls.
//  6. reset_n low during DATA bit 3 -> all outputs 0.
//     Next frame 0x52 (parity 1) -> RxData=0x52, no error flags.
//  Also run "ENRIQUE" with the line rate skewed +/-2% -> all 7 words, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART receive path (and its TX sibling).
//   rx_state_e     : receive frame FSM states
//   calc_tick_div  : rx_clk cycles per oversample tick, rounded to nearest
//   maj3           : 2-of-3 vote used to resolve each bit from its samples
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_e;

    // Round-to-nearest divider so the bit-time error stays below half a clock per tick
    function automatic int calc_tick_div(input int clk, input int baud, input int os);
        return (clk + (baud * os) / 2) / (baud * os);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_errdet_if.sv
// -----------------------------------------------------------------------------
// uart_rx_errdet_if
// Word delivery bundle of the UART receiver.
//   RxData      : received word, valid while rx_valid=1
//   rx_valid    : holding register full
//   rx_ready    : consumer accepts when rx_valid & rx_ready
//   parity_err  : parity mismatch for RxData (qualified by rx_valid)
//   frame_err   : stop bit sampled low for RxData (qualified by rx_valid)
//   overrun_err : one-cycle pulse, a completed frame was dropped
// master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_errdet_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] RxData;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  parity_err;
    logic                  frame_err;
    logic                  overrun_err;

    modport master (
        output RxData, rx_valid, parity_err, frame_err, overrun_err,
        input  rx_ready
    );

    modport slave (
        input  RxData, rx_valid, parity_err, frame_err, overrun_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Divides rx_clk down to the oversample tick rate.
//   rx_clk  : clock
//   reset_n : asynchronous active-low reset
//   clear   : restart the divider (tick suppressed this cycle)
//   tick    : registered one-cycle pulse every TICK_DIV clocks
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int TICK_DIV = 27
) (
    input  logic rx_clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // Divider counter; tick is raised on the cycle after the counter wraps
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (clear) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;
endmodule

// File: rtl/uart_rx_errdet.sv
// -----------------------------------------------------------------------------
// uart_rx_errdet
// Oversampling UART receiver (8N1 / 8E1 / 8O1) with parity, framing and
// overrun detection and a one-entry valid/ready holding register.
//   rx_clk  : receiver clock
//   reset_n : asynchronous active-low reset
//   rx      : serial line, idles high, asynchronous to rx_clk
//   rx_if   : word delivery bundle (master side), see uart_rx_errdet_if
// -----------------------------------------------------------------------------
module uart_rx_errdet
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic             rx_clk,
    input  logic             reset_n,
    input  logic             rx,
    uart_rx_errdet_if.master rx_if
);
    localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int HALF     = OVERSAMPLE / 2;
    localparam int TW       = $clog2(OVERSAMPLE);
    localparam int BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [TW-1:0] TICK_S0   = TW'(HALF - 1);
    localparam logic [TW-1:0] TICK_S1   = TW'(HALF);
    localparam logic [TW-1:0] TICK_RES  = TW'(HALF + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("uart_rx_errdet: TICK_DIV must be at least 1");
    end
    if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8) begin : g_bad_oversample
        $error("uart_rx_errdet: OVERSAMPLE must be even and >= 8");
    end

    logic                  r_rx_meta, r_rxs;
    rx_state_e             r_state, w_state_nxt;
    logic [TW-1:0]         r_tick_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_s0, r_s1, r_par_bad;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid, r_pe, r_fe, r_ovr;

    logic w_tick, w_clear, w_resolve, w_bit_end, w_vote;
    logic w_shift, w_par_load, w_commit, w_bit_clr, w_bit_inc, w_accept;

    uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .rx_clk  (rx_clk),
        .reset_n (reset_n),
        .clear   (w_clear),
        .tick    (w_tick)
    );

    // Two-flop synchroniser for the asynchronous line; idles high
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
        end
    end

    // Position within the current bit, realigned to the start edge
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
        end else if (w_clear) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + TW'(1);
        end else begin
            r_tick_cnt <= r_tick_cnt;
        end
    end

    // The third sample is the live synchronised line on the resolve tick
    assign w_resolve = w_tick && (r_tick_cnt == TICK_RES);
    assign w_bit_end = w_tick && (r_tick_cnt == TICK_LAST);
    assign w_vote    = maj3(r_s0, r_s1, r_rxs);
    assign w_accept  = r_valid & rx_if.rx_ready;

    // Frame FSM state register
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame FSM next state and datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_shift     = 1'b0;
        w_par_load  = 1'b0;
        w_commit    = 1'b0;
        w_bit_clr   = 1'b0;
        w_bit_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_rxs) begin
                    w_state_nxt = START;
                    w_clear     = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                // A start bit that votes high was a glitch: drop it silently
                if (w_resolve && w_vote) begin
                    w_state_nxt = IDLE;
                end else if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_bit_clr   = 1'b1;
                end else begin
                    w_state_nxt = START;
                end
            end
            DATA: begin
                w_shift = w_resolve;
                if (w_bit_end && (r_bit_cnt == BIT_LAST)) begin
                    w_bit_clr = 1'b1;
                    if (PARITY_EN != 0) begin
                        w_state_nxt = PARITY;
                    end else begin
                        w_state_nxt = STOP;
                    end
                end else if (w_bit_end) begin
                    w_bit_inc = 1'b1;
                end else begin
                    w_state_nxt = DATA;
                end
            end
            PARITY: begin
                w_par_load = w_resolve;
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                end else begin
                    w_state_nxt = PARITY;
                end
            end
            STOP: begin
                // Commit mid-stop-bit so a back-to-back start edge is not missed
                if (w_resolve) begin
                    w_commit = 1'b1;
                    if (w_vote) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = WAIT_HIGH;
                    end
                end else begin
                    w_state_nxt = STOP;
                end
            end
            WAIT_HIGH: begin
                // A break must release before another start can be seen
                if (r_rxs) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT_HIGH;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Bit counter, sample capture, LSB-first shift register and parity check
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt <= '0;
            r_s0      <= 1'b1;
            r_s1      <= 1'b1;
            r_shift   <= '0;
            r_par_bad <= 1'b0;
        end else begin
            if (w_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (w_bit_inc) begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
            end else begin
                r_bit_cnt <= r_bit_cnt;
            end
            if (w_tick && (r_tick_cnt == TICK_S0)) begin
                r_s0 <= r_rxs;
            end
            if (w_tick && (r_tick_cnt == TICK_S1)) begin
                r_s1 <= r_rxs;
            end
            if (w_shift) begin
                r_shift <= {w_vote, r_shift[DATA_WIDTH-1:1]};
            end
            if (w_clear) begin
                r_par_bad <= 1'b0;
            end else if (w_par_load) begin
                r_par_bad <= (^r_shift) ^ w_vote ^ PAR_ODD;
            end else begin
                r_par_bad <= r_par_bad;
            end
        end
    end

    // Holding register: a commit into a full, unaccepted slot becomes an overrun
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_pe    <= 1'b0;
            r_fe    <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (w_commit && (!r_valid || rx_if.rx_ready)) begin
                r_data  <= r_shift;
                r_pe    <= r_par_bad;
                r_fe    <= ~w_vote;
                r_valid <= 1'b1;
            end else if (w_commit) begin
                r_ovr <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end
        end
    end

    assign rx_if.RxData      = r_data;
    assign rx_if.rx_valid    = r_valid;
    assign rx_if.parity_err  = r_pe;
    assign rx_if.frame_err   = r_fe;
    assign rx_if.overrun_err = r_ovr;
endmodule

// File: tb/tb_uart_rx_errdet.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_errdet
// Drives serial frames into uart_rx_errdet and scores delivered words against
// a frame-level model. The line rate is raised (TICK_DIV=4, 1280 ns bit) so
// the whole run stays short; the receiver logic is identical at any rate.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_errdet;
    import uart_pkg::*;

    localparam int  CLK_FREQ = 50_000_000;
    localparam int  BAUD     = 781_250;
    localparam int  OS       = 16;
    localparam real BIT_NS   = 1.0e9 / BAUD;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic rx      = 1'b1;
    exp_t exp_q[$];
    int   n_checks    = 0;
    int   n_fail      = 0;
    int   n_ovr       = 0;
    int   n_valid_cyc = 0;

    uart_rx_errdet_if #(.DATA_WIDTH(8)) u_if ();

    uart_rx_errdet #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .DATA_WIDTH (8),
        .OVERSAMPLE (OS),
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) dut (
        .rx_clk  (clk),
        .reset_n (reset_n),
        .rx      (rx),
        .rx_if   (u_if.master)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Even parity bit that makes the total number of ones even
    function automatic logic good_par(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2) != 0;
    endfunction

    // What the receiver must report for a frame sent with these line bits
    function automatic exp_t model(input logic [7:0] d, input logic par_bit, input logic stop_bit);
        exp_t e;
        e.d  = d;
        e.pe = (par_bit != good_par(d));
        e.fe = (stop_bit == 1'b0);
        return e;
    endfunction

    // Drives start, data, parity and stop; leaves rx at the stop level
    task automatic send_bits(input logic [7:0] d, input logic par_bit, input logic stop_bit, input real bt);
        rx = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(bt);
        end
        rx = par_bit;
        #(bt);
        rx = stop_bit;
        #(bt);
    endtask

    task automatic send_good(input logic [7:0] d, input real bt);
        exp_q.push_back(model(d, good_par(d), 1'b1));
        send_bits(d, good_par(d), 1'b1, bt);
        rx = 1'b1;
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        u_if.rx_ready = v;
    endtask

    // Scoreboard monitor: score every accepted word and count overrun pulses
    always @(negedge clk) begin
        exp_t e;
        if (u_if.overrun_err) n_ovr++;
        if (u_if.rx_valid) n_valid_cyc++;
        if (reset_n && u_if.rx_valid && u_if.rx_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL word_unexpected: got data=%h pe=%b fe=%b, expected no word",
                         u_if.RxData, u_if.parity_err, u_if.frame_err);
            end else begin
                e = exp_q.pop_front();
                if (u_if.RxData !== e.d || u_if.parity_err !== e.pe || u_if.frame_err !== e.fe) begin
                    n_fail++;
                    $display("FAIL word: got data=%h pe=%b fe=%b, expected data=%h pe=%b fe=%b",
                             u_if.RxData, u_if.parity_err, u_if.frame_err, e.d, e.pe, e.fe);
                end
            end
        end
    end

    // Watchdog so a stuck run still terminates
    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected run to complete");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        string name_s;
        logic [7:0] d;
        logic bad_par, bad_stop;
        real bt;
        int ovr0;

        u_if.rx_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_valid", u_if.rx_valid, 0);
        check("reset_data", u_if.RxData, 0);
        check("reset_perr", u_if.parity_err, 0);
        check("reset_ferr", u_if.frame_err, 0);
        check("reset_ovr", u_if.overrun_err, 0);
        check("reset_state", dut.r_state, IDLE);
        check("reset_sync", dut.r_rxs, 1);
        reset_n = 1'b1;
        #(BIT_NS * 2);

        // Clean 'E' frame, valid for exactly one cycle
        n_valid_cyc = 0;
        send_good(8'h45, BIT_NS);
        drain("t1_drain");
        #(BIT_NS);
        check("t1_valid_cycles", n_valid_cyc, 1);

        // 'E' with the wrong parity bit
        exp_q.push_back(model(8'h45, 1'b0, 1'b1));
        send_bits(8'h45, 1'b0, 1'b1, BIT_NS);
        rx = 1'b1;
        drain("t2_drain");
        #(BIT_NS);

        // 'N' with a low stop bit and the line held low for three bit times
        exp_q.push_back(model(8'h4E, good_par(8'h4E), 1'b0));
        send_bits(8'h4E, good_par(8'h4E), 1'b0, BIT_NS);
        #(BIT_NS * 2);
        drain("t3_drain");
        @(negedge clk);
        check("t3_wait_high", dut.r_state, WAIT_HIGH);
        rx = 1'b1;
        #(BIT_NS);
        check("t3_idle", dut.r_state, IDLE);

        // Short low glitches on an idle line are rejected
        rx = 1'b0; #200; rx = 1'b1;
        #(BIT_NS * 2);
        check("t4_glitch200", dut.r_state, IDLE);
        rx = 1'b0; #300; rx = 1'b1;
        #(BIT_NS * 2);
        check("t4_glitch300", dut.r_state, IDLE);

        // Back-to-back 'E','N' with no consumer: second word is an overrun
        ovr0 = n_ovr;
        set_ready(1'b0);
        exp_q.push_back(model(8'h45, good_par(8'h45), 1'b1));
        send_bits(8'h45, good_par(8'h45), 1'b1, BIT_NS);
        send_bits(8'h4E, good_par(8'h4E), 1'b1, BIT_NS);
        rx = 1'b1;
        #(BIT_NS);
        @(negedge clk);
        check("t5_ovr_count", n_ovr - ovr0, 1);
        check("t5_held_valid", u_if.rx_valid, 1);
        check("t5_held_data", u_if.RxData, 8'h45);
        set_ready(1'b1);
        drain("t5_drain");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t5_valid_fall", u_if.rx_valid, 0);

        // Reset mid-frame discards both the held word and the frame in flight
        set_ready(1'b0);
        send_good(8'h41, BIT_NS);
        #(BIT_NS);
        rx = 1'b0;
        #(BIT_NS);
        d = 8'h52;
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            #(BIT_NS);
        end
        rx = d[3];
        #(BIT_NS / 2);
        check("t6_in_data", dut.r_state, DATA);
        reset_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t6_rst_valid", u_if.rx_valid, 0);
        check("t6_rst_data", u_if.RxData, 0);
        check("t6_rst_flags", {u_if.parity_err, u_if.frame_err, u_if.overrun_err}, 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        set_ready(1'b1);
        #(BIT_NS * 2);
        send_good(8'h52, BIT_NS);
        drain("t6_drain");

        // Randomised frames: data, parity/stop corruption, skew and gaps
        for (int n = 0; n < 16; n++) begin
            d        = 8'($urandom);
            bad_par  = ($urandom_range(0, 5) == 0);
            bad_stop = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 2))
                0:       bt = BIT_NS;
                1:       bt = BIT_NS * 1.02;
                default: bt = BIT_NS * 0.98;
            endcase
            exp_q.push_back(model(d, good_par(d) ^ bad_par, ~bad_stop));
            send_bits(d, good_par(d) ^ bad_par, ~bad_stop, bt);
            if (bad_stop) begin
                #(bt);
                rx = 1'b1;
                #(bt);
            end else begin
                rx = 1'b1;
            end
            #(bt * real'($urandom_range(0, 2)) / 2.0);
        end
        drain("rand_drain");

        // "ENRIQUE" back-to-back with the line rate skewed both ways
        name_s = "ENRIQUE";
        for (int s = 0; s < 2; s++) begin
            bt = (s == 0) ? BIT_NS * 1.02 : BIT_NS * 0.98;
            for (int i = 0; i < name_s.len(); i++) begin
                send_good(name_s[i], bt);
            end
            drain("enrique_drain");
            #(BIT_NS);
        end

        check("final_ovr_total", n_ovr - ovr0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
